intersection_controller: RTL and testbench

Top-level sequencer for one four-way intersection. It owns the NS and EW light heads and runs both from a single phase machine, so the two directions can never show conflicting indications. It inserts an all-red clearance between directions and grants each direction's protected-left phase only when a left-turn request is pending. An emergency input preempts the cycle: the active direction is driven through yellow and clearance into an all-stop hold.

---
 rtl/intersection_controller.sv | 187 ++++++++++++++++++
 tb/tb_intersection_controller.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intersection_controller.sv
// Four-way intersection phase sequencer: one state machine drives both light heads,
// with all-red clearance, demand-driven protected lefts and emergency preemption.
module intersection_controller #(
    parameter int LEFT_T   = 5,
    parameter int GREEN_T  = 10,
    parameter int YELLOW_T = 3,
    parameter int CLEAR_T  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       emergency,
    input  logic       ns_left_req,
    input  logic       ew_left_req,
    output logic [3:0] ns_out,
    output logic [3:0] ew_out,
    output logic [3:0] phase,
    output logic       allstop
);

    // state     | meaning
    // NS_LEFT   | NS protected left arrow, EW red
    // NS_GREEN  | NS green, EW red
    // NS_YELLOW | NS yellow, EW red
    // NS_CLEAR  | all red after NS, then EW (or ALLSTOP if preempted)
    // EW_LEFT   | EW protected left arrow, NS red
    // EW_GREEN  | EW green, NS red
    // EW_YELLOW | EW yellow, NS red
    // EW_CLEAR  | all red after EW, then NS (or ALLSTOP); reset state
    // ALLSTOP   | emergency hold, all red, resumes opposite the last direction
    typedef enum logic [3:0] {
        NS_LEFT   = 4'd0,
        NS_GREEN  = 4'd1,
        NS_YELLOW = 4'd2,
        NS_CLEAR  = 4'd3,
        EW_LEFT   = 4'd4,
        EW_GREEN  = 4'd5,
        EW_YELLOW = 4'd6,
        EW_CLEAR  = 4'd7,
        ALLSTOP   = 4'd8
    } state_t;

    localparam logic [3:0] HEAD_LEFT   = 4'b1001;
    localparam logic [3:0] HEAD_GREEN  = 4'b0100;
    localparam logic [3:0] HEAD_YELLOW = 4'b0010;
    localparam logic [3:0] HEAD_RED    = 4'b0001;

    localparam logic [4:0] LEFT_LAST   = 5'(LEFT_T - 1);
    localparam logic [4:0] GREEN_LAST  = 5'(GREEN_T - 1);
    localparam logic [4:0] YELLOW_LAST = 5'(YELLOW_T - 1);
    localparam logic [4:0] CLEAR_LAST  = 5'(CLEAR_T - 1);
    localparam logic [4:0] CNT_MAX     = 5'd31;

    state_t     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic       ns_lp_q, ns_lp_d;
    logic       ew_lp_q, ew_lp_d;
    logic       em_pend_q, em_pend_d;
    logic       resume_ew_q, resume_ew_d;

    logic       preempt;
    logic       state_change;
    state_t     ns_start;
    state_t     ew_start;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EW_CLEAR;
            cnt_q       <= 5'd0;
            ns_lp_q     <= 1'b0;
            ew_lp_q     <= 1'b0;
            em_pend_q   <= 1'b0;
            resume_ew_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ns_lp_q     <= ns_lp_d;
            ew_lp_q     <= ew_lp_d;
            em_pend_q   <= em_pend_d;
            resume_ew_q <= resume_ew_d;
        end
    end

    // The live emergency input counts as well as the latch, so preemption
    // starts on the same edge that first samples the request.
    always_comb begin
        state_d     = state_q;
        resume_ew_d = resume_ew_q;
        preempt     = em_pend_q | emergency;
        ns_start    = ns_lp_q ? NS_LEFT : NS_GREEN;
        ew_start    = ew_lp_q ? EW_LEFT : EW_GREEN;

        case (state_q)
            NS_LEFT: begin
                if (preempt)                 state_d = NS_YELLOW;
                else if (cnt_q == LEFT_LAST) state_d = NS_GREEN;
            end
            NS_GREEN: begin
                if (preempt)                  state_d = NS_YELLOW;
                else if (cnt_q == GREEN_LAST) state_d = NS_YELLOW;
            end
            NS_YELLOW: begin
                if (cnt_q == YELLOW_LAST) state_d = NS_CLEAR;
            end
            NS_CLEAR: begin
                if (cnt_q == CLEAR_LAST) begin
                    if (preempt) begin
                        state_d     = ALLSTOP;
                        resume_ew_d = 1'b1;
                    end else begin
                        state_d = ew_start;
                    end
                end
            end
            EW_LEFT: begin
                if (preempt)                 state_d = EW_YELLOW;
                else if (cnt_q == LEFT_LAST) state_d = EW_GREEN;
            end
            EW_GREEN: begin
                if (preempt)                  state_d = EW_YELLOW;
                else if (cnt_q == GREEN_LAST) state_d = EW_YELLOW;
            end
            EW_YELLOW: begin
                if (cnt_q == YELLOW_LAST) state_d = EW_CLEAR;
            end
            EW_CLEAR: begin
                if (cnt_q == CLEAR_LAST) begin
                    if (preempt) begin
                        state_d     = ALLSTOP;
                        resume_ew_d = 1'b0;
                    end else begin
                        state_d = ns_start;
                    end
                end
            end
            ALLSTOP: begin
                if (!emergency && (cnt_q >= CLEAR_LAST)) begin
                    state_d = resume_ew_q ? ew_start : ns_start;
                end
            end
            default: state_d = EW_CLEAR;
        endcase
    end

    // Dwell counter restarts on every state change and saturates for long holds.
    always_comb begin
        state_change = (state_d != state_q);
        if (state_change)         cnt_d = 5'd0;
        else if (cnt_q < CNT_MAX) cnt_d = cnt_q + 5'd1;
        else                      cnt_d = cnt_q;
    end

    // A request coinciding with the LEFT entry edge wins over the clear.
    always_comb begin
        ns_lp_d = ns_lp_q;
        ew_lp_d = ew_lp_q;
        if (state_change && (state_d == NS_LEFT)) ns_lp_d = 1'b0;
        if (state_change && (state_d == EW_LEFT)) ew_lp_d = 1'b0;
        if (ns_left_req) ns_lp_d = 1'b1;
        if (ew_left_req) ew_lp_d = 1'b1;
    end

    always_comb begin
        em_pend_d = em_pend_q;
        if (state_change && (state_d == ALLSTOP)) em_pend_d = 1'b0;
        else if ((state_q != ALLSTOP) && emergency) em_pend_d = 1'b1;
    end

    always_comb begin
        ns_out  = HEAD_RED;
        ew_out  = HEAD_RED;
        phase   = state_q;
        allstop = (state_q == ALLSTOP);
        case (state_q)
            NS_LEFT:   ns_out = HEAD_LEFT;
            NS_GREEN:  ns_out = HEAD_GREEN;
            NS_YELLOW: ns_out = HEAD_YELLOW;
            EW_LEFT:   ew_out = HEAD_LEFT;
            EW_GREEN:  ew_out = HEAD_GREEN;
            EW_YELLOW: ew_out = HEAD_YELLOW;
            default: begin
                ns_out = HEAD_RED;
                ew_out = HEAD_RED;
            end
        endcase
    end

endmodule

// File: tb/tb_intersection_controller.sv
// Bench for intersection_controller: fixed vector table, directed corner sequences,
// and a random run checked against a direction/stage/age reference model.
module tb_intersection_controller;

    localparam int LEFT_T   = 5;
    localparam int GREEN_T  = 10;
    localparam int YELLOW_T = 3;
    localparam int CLEAR_T  = 2;

    localparam logic [3:0] H_LEFT   = 4'b1001;
    localparam logic [3:0] H_GREEN  = 4'b0100;
    localparam logic [3:0] H_YELLOW = 4'b0010;
    localparam logic [3:0] H_RED    = 4'b0001;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       emergency = 1'b0;
    logic       ns_left_req = 1'b0;
    logic       ew_left_req = 1'b0;
    logic [3:0] ns_out, ew_out, phase;
    logic       allstop;

    int checks = 0;
    int failures = 0;

    intersection_controller #(
        .LEFT_T(LEFT_T), .GREEN_T(GREEN_T), .YELLOW_T(YELLOW_T), .CLEAR_T(CLEAR_T)
    ) dut (
        .clk(clk), .reset(reset), .emergency(emergency),
        .ns_left_req(ns_left_req), .ew_left_req(ew_left_req),
        .ns_out(ns_out), .ew_out(ew_out), .phase(phase), .allstop(allstop)
    );

    always #5 clk = ~clk;

    // Reference model: direction (0=NS, 1=EW), stage (0 left, 1 green,
    // 2 yellow, 3 clear, 4 all-stop) and cycles spent in the current stage.
    int m_dir, m_stage, m_age, m_resume;
    bit m_lp[2];
    bit m_em;

    function automatic int dur(input int st);
        case (st)
            0: return LEFT_T;
            1: return GREEN_T;
            2: return YELLOW_T;
            default: return CLEAR_T;
        endcase
    endfunction

    task automatic model_step(input bit rst, input bit em, input bit nsr, input bit ewr);
        int nd, nst;
        bit pre, changed;
        if (rst) begin
            m_dir = 1; m_stage = 3; m_age = 0; m_resume = 0;
            m_lp[0] = 0; m_lp[1] = 0; m_em = 0;
            return;
        end
        pre = m_em || em;
        nd = m_dir;
        nst = m_stage;
        if (m_stage == 4) begin
            if (!em && m_age >= CLEAR_T - 1) begin
                nd = m_resume;
                nst = m_lp[nd] ? 0 : 1;
            end
        end else if (m_stage <= 1 && pre) begin
            nst = 2;
        end else if (m_age == dur(m_stage) - 1) begin
            if (m_stage < 3) nst = m_stage + 1;
            else if (pre) begin
                nst = 4;
                m_resume = 1 - m_dir;
            end else begin
                nd = 1 - m_dir;
                nst = m_lp[nd] ? 0 : 1;
            end
        end
        changed = (nd != m_dir) || (nst != m_stage);
        if (changed && nst == 0) m_lp[nd] = 0;
        if (nsr) m_lp[0] = 1;
        if (ewr) m_lp[1] = 1;
        if (changed && nst == 4) m_em = 0;
        else if (m_stage != 4 && em) m_em = 1;
        m_age = changed ? 0 : ((m_age < 31) ? m_age + 1 : 31);
        m_dir = nd;
        m_stage = nst;
    endtask

    function automatic logic [3:0] m_head(input int d);
        if (m_stage >= 3 || m_dir != d) return H_RED;
        case (m_stage)
            0: return H_LEFT;
            1: return H_GREEN;
            default: return H_YELLOW;
        endcase
    endfunction

    function automatic logic [3:0] m_phase();
        if (m_stage == 4) return 4'd8;
        return 4'(m_dir * 4 + m_stage);
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive_step(input bit rst, input bit em, input bit nsr, input bit ewr);
        @(negedge clk);
        reset = rst; emergency = em; ns_left_req = nsr; ew_left_req = ewr;
        model_step(rst, em, nsr, ewr);
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input bit rst, input bit em, input bit nsr, input bit ewr);
        drive_step(rst, em, nsr, ewr);
        check("model", {ns_out, ew_out, phase, 3'b000, allstop},
              {m_head(0), m_head(1), m_phase(), 3'b000, m_stage == 4});
        check("no_conflict", 16'((ns_out == H_RED) || (ew_out == H_RED)), 16'd1);
    endtask

    task automatic run_until(input logic [3:0] ph, input int max, input string name);
        int n = 0;
        while (phase !== ph && n < max) begin
            cycle(0, 0, 0, 0);
            n++;
        end
        if (phase !== ph) begin
            checks++;
            failures++;
            $display("FAIL %s timeout phase=%0d required=%0d", name, phase, ph);
        end
    endtask

    typedef struct {
        bit         rst;
        bit         em;
        bit         nsr;
        bit         ewr;
        logic [3:0] ns;
        logic [3:0] ew;
        logic [3:0] ph;
        logic       as;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rst, input int n, input logic [3:0] ns, input logic [3:0] ew,
                       input logic [3:0] ph);
        vec_t v;
        v.rst = rst; v.em = 0; v.nsr = 0; v.ewr = 0;
        v.ns = ns; v.ew = ew; v.ph = ph; v.as = 1'b0;
        repeat (n) vecs.push_back(v);
    endtask

    initial begin
        int k;
        int em_left;
        logic [3:0] exp_ph[$];
        logic [3:0] got_ph;
        bit rr, re, rn, rw;

        // Nominal cycle after a 2-cycle reset, two full periods.
        add(1, 2, H_RED, H_RED, 4'd7);
        add(0, 1, H_RED, H_RED, 4'd7);
        for (int p = 0; p < 2; p++) begin
            add(0, GREEN_T,  H_GREEN,  H_RED,    4'd1);
            add(0, YELLOW_T, H_YELLOW, H_RED,    4'd2);
            add(0, CLEAR_T,  H_RED,    H_RED,    4'd3);
            add(0, GREEN_T,  H_RED,    H_GREEN,  4'd5);
            add(0, YELLOW_T, H_RED,    H_YELLOW, 4'd6);
            add(0, CLEAR_T,  H_RED,    H_RED,    4'd7);
        end
        add(0, 1, H_GREEN, H_RED, 4'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive_step(vecs[i].rst, vecs[i].em, vecs[i].nsr, vecs[i].ewr);
            check($sformatf("table[%0d]", i), {ns_out, ew_out, phase, 3'b000, allstop},
                  {vecs[i].ns, vecs[i].ew, vecs[i].ph, 3'b000, vecs[i].as});
        end

        // Left grant: request during EW_GREEN, NS then opens with a 5-cycle arrow.
        cycle(1, 0, 0, 0); cycle(1, 0, 0, 0);
        run_until(4'd5, 60, "lg_ew_green");
        cycle(0, 0, 1, 0);
        run_until(4'd0, 60, "lg_ns_left");
        k = 0;
        while (ns_out === H_LEFT && k < 20) begin
            k++;
            cycle(0, 0, 0, 0);
        end
        check("lg_left_len", 16'(k), 16'(LEFT_T));
        check("lg_then_green", {12'd0, ns_out}, {12'd0, H_GREEN});
        run_until(4'd7, 60, "lg_ew_clear");
        k = 0;
        while (phase === 4'd7 && k < 10) begin
            k++;
            cycle(0, 0, 0, 0);
        end
        check("lg_next_ns_green", {12'd0, phase}, 16'd1);

        // Preemption from NS_GREEN counter=4, emergency held 20 cycles.
        cycle(1, 0, 0, 0); cycle(1, 0, 0, 0);
        run_until(4'd1, 10, "pre_ns_green");
        repeat (4) cycle(0, 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            cycle(0, 1, 0, 0);
            if (i <= 3)      check($sformatf("pre_seq[%0d]", i), {11'd0, phase, allstop}, {11'd0, 4'd2, 1'b0});
            else if (i <= 5) check($sformatf("pre_seq[%0d]", i), {11'd0, phase, allstop}, {11'd0, 4'd3, 1'b0});
            else             check($sformatf("pre_seq[%0d]", i), {11'd0, phase, allstop}, {11'd0, 4'd8, 1'b1});
        end
        cycle(0, 0, 0, 0);
        check("pre_resume_ew_green", {12'd0, phase}, 16'd5);

        // Short emergency pulse during EW_LEFT.
        cycle(1, 0, 0, 0); cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 1);
        run_until(4'd4, 80, "sp_ew_left");
        cycle(0, 1, 0, 0);
        check("sp_yellow_next", {12'd0, phase}, 16'd6);
        exp_ph = '{4'd6, 4'd6, 4'd7, 4'd7, 4'd8, 4'd8, 4'd1};
        for (int i = 0; i < exp_ph.size(); i++) begin
            cycle(0, 0, 0, 0);
            got_ph = phase;
            check($sformatf("sp_seq[%0d]", i), {12'd0, got_ph}, {12'd0, exp_ph[i]});
        end

        // Left request on the same edge that enters EW_LEFT.
        cycle(1, 0, 0, 0); cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 1);
        run_until(4'd3, 80, "col_ns_clear");
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);
        check("col_enter_left", {12'd0, phase}, 16'd4);
        run_until(4'd6, 80, "col_ew_yellow");
        run_until(4'd3, 80, "col_ns_clear2");
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check("col_left_again", {12'd0, phase}, 16'd4);

        // Reset while in ALLSTOP, and reset discarding a latched emergency.
        cycle(1, 0, 0, 0); cycle(1, 0, 0, 0);
        run_until(4'd1, 10, "ra_ns_green");
        cycle(0, 1, 0, 0);
        run_until(4'd8, 20, "ra_allstop");
        cycle(1, 0, 0, 0);
        check("ra_reset_state", {3'd0, ns_out, ew_out, phase, allstop},
              {3'd0, H_RED, H_RED, 4'd7, 1'b0});
        run_until(4'd2, 40, "ra_ns_yellow");
        cycle(0, 1, 0, 0);
        cycle(1, 0, 0, 0);
        run_until(4'd1, 10, "ra_ns_green2");
        k = 0;
        while (phase === 4'd1 && k < 30) begin
            k++;
            cycle(0, 0, 0, 0);
        end
        check("ra_full_green", 16'(k), 16'(GREEN_T));

        // Random traffic against the reference model.
        em_left = 0;
        for (int i = 0; i < 4000; i++) begin
            rr = ($urandom % 400) == 0;
            if (em_left > 0) begin
                re = 1;
                em_left--;
            end else if (($urandom % 60) == 0) begin
                re = 1;
                em_left = $urandom_range(0, 25);
            end else begin
                re = 0;
            end
            rn = ($urandom % 15) == 0;
            rw = ($urandom % 15) == 0;
            cycle(rr, re, rn, rw);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
